// File: rtl/bs_pkg.sv
`default_nettype none
//==============================================================================
// bs_pkg - shared mode encoding and sizing helper for the pipelined barrel shifter
// Rev 1.0
//==============================================================================
package bs_pkg;

   localparam int BS_MODE_W = 3;

   typedef enum logic [BS_MODE_W-1:0] {
      BS_ROL = 3'd0,
      BS_ROR = 3'd1,
      BS_SLL = 3'd2,
      BS_SRL = 3'd3,
      BS_SRA = 3'd4
   } bs_mode_e;

   function automatic int shamt_w(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bs_stage.sv
`default_nettype none
//==============================================================================
// bs_stage - one conditional 2^STAGE_IDX shift/rotate plus its pipeline register.
// Carry tracking present only when BS_FLAGS_EN is defined.  Rev 1.0
//==============================================================================
module bs_stage
   import bs_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SHAMT_W   = 3,
   parameter int STAGE_IDX = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic [WIDTH-1:0]     up_data,
   input  logic [SHAMT_W-1:0]   up_shamt,
   input  logic [BS_MODE_W-1:0] up_mode,
`ifdef BS_FLAGS_EN
   input  logic                 up_carry,
   output logic                 dn_carry,
`endif
   input  logic                 up_sign,
   output logic                 dn_valid,
   input  logic                 dn_ready,
   output logic [WIDTH-1:0]     dn_data,
   output logic [SHAMT_W-1:0]   dn_shamt,
   output logic [BS_MODE_W-1:0] dn_mode,
   output logic                 dn_sign
);

   localparam int DIST = 1 << STAGE_IDX;

   logic                 w_take;
   logic [WIDTH-1:0]     w_data;
   logic                 r_valid;
   logic [WIDTH-1:0]     r_data;
   logic [SHAMT_W-1:0]   r_shamt;
   logic [BS_MODE_W-1:0] r_mode;
   logic                 r_sign;

   assign w_take   = up_shamt[STAGE_IDX];
   assign up_ready = !r_valid || dn_ready;

   // SRA fills from the operand's original MSB, not the partially shifted word
   always_comb begin
      w_data = up_data;
      if (w_take) begin
         case (up_mode)
            BS_ROL:  w_data = (up_data << DIST) | (up_data >> (WIDTH - DIST));
            BS_ROR:  w_data = (up_data >> DIST) | (up_data << (WIDTH - DIST));
            BS_SLL:  w_data = up_data << DIST;
            BS_SRL:  w_data = up_data >> DIST;
            BS_SRA:  w_data = (up_data >> DIST) | ({WIDTH{up_sign}} << (WIDTH - DIST));
            default: w_data = up_data;
         endcase
      end
   end

`ifdef BS_FLAGS_EN
   logic w_carry;
   logic r_carry;

   always_comb begin
      w_carry = up_carry;
      if (w_take) begin
         case (up_mode)
            BS_ROL, BS_SLL:         w_carry = up_data[WIDTH-DIST];
            BS_ROR, BS_SRL, BS_SRA: w_carry = up_data[DIST-1];
            default:                w_carry = up_carry;
         endcase
      end
   end

   assign dn_carry = r_carry;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_shamt <= '0;
         r_mode  <= '0;
         r_sign  <= 1'b0;
`ifdef BS_FLAGS_EN
         r_carry <= 1'b0;
`endif
      end else if (up_ready) begin
         r_valid <= up_valid;
         if (up_valid) begin
            r_data  <= w_data;
            r_shamt <= up_shamt;
            r_mode  <= up_mode;
            r_sign  <= up_sign;
`ifdef BS_FLAGS_EN
            r_carry <= w_carry;
`endif
         end
      end
   end

   assign dn_valid = r_valid;
   assign dn_data  = r_data;
   assign dn_shamt = r_shamt;
   assign dn_mode  = r_mode;
   assign dn_sign  = r_sign;

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
//==============================================================================
// pipelined_barrel_shifter - SHAMT_W-stage valid/ready log shifter, 1 beat/clk.
// Define BS_FLAGS_EN to add out_zero/out_carry.  Rev 1.0
//==============================================================================
module pipelined_barrel_shifter
   import bs_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = shamt_w(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SHAMT_W-1:0]   in_shamt,
   input  logic [BS_MODE_W-1:0] in_mode,
`ifdef BS_FLAGS_EN
   output logic                 out_zero,
   output logic                 out_carry,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data
);

   localparam int N = SHAMT_W;

   // index 0 is the input port, index k+1 the register of stage k
   logic [N:0]           w_valid;
   logic [N:0]           w_ready;
   logic [WIDTH-1:0]     w_data  [N+1];
   logic [SHAMT_W-1:0]   w_shamt [N+1];
   logic [BS_MODE_W-1:0] w_mode  [N+1];
   logic                 w_sign  [N+1];
`ifdef BS_FLAGS_EN
   logic [N:0]           w_carry;
   assign w_carry[0] = 1'b0;
`endif

   assign w_valid[0] = in_valid;
   assign w_data[0]  = in_data;
   assign w_shamt[0] = in_shamt;
   assign w_mode[0]  = in_mode;
   assign w_sign[0]  = in_data[WIDTH-1];
   assign w_ready[N] = out_ready;
   assign in_ready   = w_ready[0];

   for (genvar k = 0; k < N; k++) begin : g_stage
      bs_stage #(
         .WIDTH     (WIDTH),
         .SHAMT_W   (SHAMT_W),
         .STAGE_IDX (k)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_valid (w_valid[k]),
         .up_ready (w_ready[k]),
         .up_data  (w_data[k]),
         .up_shamt (w_shamt[k]),
         .up_mode  (w_mode[k]),
`ifdef BS_FLAGS_EN
         .up_carry (w_carry[k]),
         .dn_carry (w_carry[k+1]),
`endif
         .up_sign  (w_sign[k]),
         .dn_valid (w_valid[k+1]),
         .dn_ready (w_ready[k+1]),
         .dn_data  (w_data[k+1]),
         .dn_shamt (w_shamt[k+1]),
         .dn_mode  (w_mode[k+1]),
         .dn_sign  (w_sign[k+1])
      );
   end

   assign out_valid = w_valid[N];
   assign out_data  = w_data[N];

`ifdef BS_FLAGS_EN
   assign out_zero  = w_valid[N] && (w_data[N] == '0);
   assign out_carry = w_carry[N];
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// Bench for pipelined_barrel_shifter (WIDTH=8): directed cases plus a random
// scoreboard against an arithmetic reference; flags checked when BS_FLAGS_EN is set.
module tb_pipelined_barrel_shifter;
   import bs_pkg::*;

   localparam int W  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [SW-1:0] in_shamt = '0;
   logic [2:0]    in_mode = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
`ifdef BS_FLAGS_EN
   logic          out_zero;
   logic          out_carry;
`endif

   always #5 clk = ~clk;

   pipelined_barrel_shifter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
`ifdef BS_FLAGS_EN
      .out_zero  (out_zero),
      .out_carry (out_carry),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   int nvec = 0;
   int nerr = 0;
   int n_in = 0;
   logic [W+1:0] exp_q[$];     // {zero, carry, data}
   logic         hold_chk = 1'b0;
   logic [W-1:0] held_data;
   logic         held_zero;
   logic         held_carry;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the whole operand
   function automatic logic [W+1:0] model(input logic [W-1:0] d, input int s, input int m);
      int mask;
      int dv;
      int sd;
      int r;
      int c;
      mask = (1 << W) - 1;
      dv   = int'(d);
      c    = 0;
      case (m)
         0: begin r = ((dv << s) | (dv >> (W - s))) & mask; if (s != 0) c = r & 1; end
         1: begin r = ((dv >> s) | (dv << (W - s))) & mask; if (s != 0) c = (r >> (W - 1)) & 1; end
         2: begin r = (dv << s) & mask; if (s != 0) c = (dv >> (W - s)) & 1; end
         3: begin r = dv >> s; if (s != 0) c = (dv >> (s - 1)) & 1; end
         4: begin
            sd = (dv >= (1 << (W - 1))) ? dv - (1 << W) : dv;
            r  = (sd >>> s) & mask;
            if (s != 0) c = (dv >> (s - 1)) & 1;
         end
         default: r = dv;
      endcase
      return {(r == 0), c[0], r[W-1:0]};
   endfunction

   // One clock: check outputs/handshakes just before the edge, then advance
   task automatic step();
      logic [W+1:0] e;
      #1;
      if (hold_chk) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, held_data);
`ifdef BS_FLAGS_EN
         chk("hold_zero", out_zero, held_zero);
         chk("hold_carry", out_carry, held_carry);
`endif
      end
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
         else begin
            e = exp_q.pop_front();
            chk("sb_data", out_data, e[W-1:0]);
`ifdef BS_FLAGS_EN
            chk("sb_carry", out_carry, e[W]);
            chk("sb_zero", out_zero, e[W+1]);
`endif
         end
      end
      if (rst_n && in_valid && in_ready) begin
         exp_q.push_back(model(in_data, int'(in_shamt), int'(in_mode)));
         n_in++;
      end
      if (!rst_n) exp_q.delete();
      hold_chk   = rst_n && out_valid && !out_ready;
      held_data  = out_data;
`ifdef BS_FLAGS_EN
      held_zero  = out_zero;
      held_carry = out_carry;
`endif
      @(posedge clk);
      #1;
   endtask

   // Single beat into an empty pipe: result must appear exactly 3 clocks later
   task automatic run_one(input string tag, input logic [W-1:0] d, input int s, input int m,
                          input logic [W-1:0] ed, input logic ec, input logic ez);
      in_valid  = 1'b1;
      in_data   = d;
      in_shamt  = SW'(s);
      in_mode   = 3'(m);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk({tag, "_early"}, out_valid, 0);
         step();
      end
      #1;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, ed);
`ifdef BS_FLAGS_EN
      chk({tag, "_carry"}, out_carry, ec);
      chk({tag, "_zero"}, out_zero, ez);
`else
      if (ec === 1'bx || ez === 1'bx) chk({tag, "_xarg"}, 0, 1);
`endif
      step();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
      chk("drain_left", exp_q.size(), 0);
      step();
      #1;
      chk("drain_idle", out_valid, 0);
   endtask

   initial begin
      int start;
      // reset
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef BS_FLAGS_EN
      chk("rst_zero", out_zero, 0);
      chk("rst_carry", out_carry, 0);
`endif

      // directed cases
      run_one("rol81",  8'h81, 1, 0, 8'h03, 1'b1, 1'b0);
      run_one("sra90",  8'h90, 3, 4, 8'hF2, 1'b0, 1'b0);
      run_one("srl90",  8'h90, 4, 3, 8'h09, 1'b0, 1'b0);
      run_one("sll0f",  8'h0F, 5, 2, 8'hE0, 1'b1, 1'b0);
      run_one("ror01",  8'h01, 1, 1, 8'h80, 1'b1, 1'b0);
      run_one("pass6",  8'hA5, 3, 6, 8'hA5, 1'b0, 1'b0);
      run_one("srlz",   8'h01, 1, 3, 8'h00, 1'b1, 1'b1);
      for (int m = 0; m < 8; m++) run_one("sh0", 8'hC3, 0, m, 8'hC3, 1'b0, 1'b0);

      // back-to-back: 8 beats in, 8 results on consecutive cycles
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         in_valid = (i < 8);
         in_data  = W'($urandom);
         in_shamt = SW'($urandom);
         in_mode  = 3'($urandom_range(0, 7));
         #1;
         if (i < 8)  chk("b2b_in_ready", in_ready, 1);
         if (i >= 3) chk("b2b_out_valid", out_valid, 1);
         step();
      end
      drain();

      // stall: fill 3 beats with out_ready low, hold 5 clocks, then release
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data  = W'($urandom);
         in_shamt = SW'($urandom);
         in_mode  = 3'($urandom_range(0, 4));
         #1;
         if (i < 3) chk("fill_in_ready", in_ready, 1);
         else begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
         end
         step();
      end
      drain();

      // reset with two beats in flight
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_data  = W'($urandom);
         in_shamt = SW'($urandom);
         in_mode  = 3'($urandom_range(0, 4));
         step();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("midrst_no_stale", out_valid, 0);
         chk("midrst_in_ready", in_ready, 1);
         step();
      end
      run_one("postrst", 8'h81, 1, 0, 8'h03, 1'b1, 1'b0);

      // random scoreboard
      start = n_in;
      for (int c = 0; c < 60000 && (n_in - start) < 10000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = W'($urandom);
         in_shamt  = SW'($urandom);
         in_mode   = 3'($urandom_range(0, 7));
         step();
      end
      chk("random_beats", n_in - start, 10000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
